// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one uart_buffer write port, pacing data_strobe on baud_x1.
// Optional HOLD watchdog with timeout_pulse output: define UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_x1,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           data,
  output logic                 data_strobe,
`ifdef UART_ARB_WATCHDOG_EN
  output logic                 timeout_pulse,
`endif
  output logic                 busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, STROBE_HI, STROBE_LO, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic             last_r;
  logic             hi_seen;
`ifdef UART_ARB_WATCHDOG_EN
  logic [15:0]      wd_cnt;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin scan starting just after the previous owner.
  always_comb begin : arb_scan
    int               scan;
    logic [IDX_W-1:0] cand;
    scan     = 0;
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = int'(ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      cand = IDX_W'(scan);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign busy = (grant != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      ack           <= '0;
      data          <= 8'h00;
      data_strobe   <= 1'b0;
      last_r        <= 1'b0;
      hi_seen       <= 1'b0;
      owner         <= '0;
      ptr           <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_WATCHDOG_EN
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef UART_ARB_WATCHDOG_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= onehot(pick);
            owner <= pick;
            state <= LATCH;
          end
        end
        LATCH: begin
          data        <= req_data[8*owner +: 8];
          last_r      <= req_last[owner];
          ack         <= onehot(owner);
          data_strobe <= 1'b1;
          hi_seen     <= 1'b0;
          state       <= STROBE_HI;
        end
        // Two high ticks: one so the buffer samples high, one to cover its write.
        STROBE_HI: begin
          if (baud_x1) begin
            if (hi_seen) begin
              data_strobe <= 1'b0;
              state       <= STROBE_LO;
            end else begin
              hi_seen <= 1'b1;
            end
          end
        end
        STROBE_LO: begin
          if (baud_x1) begin
            if (last_r) begin
              ptr   <= owner;
              grant <= '0;
              state <= IDLE;
            end else begin
`ifdef UART_ARB_WATCHDOG_EN
              wd_cnt <= '0;
`endif
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (req[owner]) begin
            state <= LATCH;
`ifdef UART_ARB_WATCHDOG_EN
          end else if (baud_x1) begin
            if (wd_cnt + 16'd1 == 16'(TIMEOUT)) begin
              ptr           <= owner;
              grant         <= '0;
              timeout_pulse <= 1'b1;
              state         <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + 16'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart_buffer sampling model; covers UART_ARB_WATCHDOG_EN when defined.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         baud_x1 = 1'b0;
  logic [1:0]   req = '0;
  logic [15:0]  req_data = '0;
  logic [1:0]   req_last = '0;
  logic [1:0]   ack;
  logic [1:0]   grant;
  logic [7:0]   data;
  logic         data_strobe;
  logic         busy;
`ifdef UART_ARB_WATCHDOG_EN
  logic         timeout_pulse;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic       baud_fast = 1'b0;
  int         baud_div = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] got[$];
  int         hi_ticks[$];
  int         hi_clks[$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_x1       (baud_x1),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .ack           (ack),
    .grant         (grant),
    .data          (data),
    .data_strobe   (data_strobe),
`ifdef UART_ARB_WATCHDOG_EN
    .timeout_pulse (timeout_pulse),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Baud tick: one clk in four, or every clk when baud_fast.
  initial forever begin
    @(negedge clk);
    if (baud_fast) begin
      baud_x1 = 1'b1;
    end else begin
      baud_x1  = (baud_div == 0);
      baud_div = (baud_div == 3) ? 0 : baud_div + 1;
    end
  end

  // Requesters: present queue head, pop on ack, drop req when empty.
  initial forever begin
    @(posedge clk);
    #1;
    if (ack[0] && q0.size() > 0) void'(q0.pop_front());
    if (ack[1] && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      req[0] = 1'b1; req_data[7:0] = q0[0][7:0]; req_last[0] = q0[0][8];
    end else begin
      req[0] = 1'b0; req_last[0] = 1'b0;
    end
    if (q1.size() > 0) begin
      req[1] = 1'b1; req_data[15:8] = q1[0][7:0]; req_last[1] = q1[0][8];
    end else begin
      req[1] = 1'b0; req_last[1] = 1'b0;
    end
  end

  // uart_buffer model: samples strobe on baud ticks, a write per sampled rising edge.
  initial begin
    logic buf_prev;
    int   hcnt;
    int   ccnt;
    buf_prev = 1'b0;
    hcnt = 0;
    ccnt = 0;
    forever begin
      @(posedge clk);
      if (baud_x1) begin
        if (data_strobe) begin
          if (!buf_prev) begin
            got.push_back({grant, data});
            hcnt = 0;
          end
          hcnt++;
        end else if (buf_prev) begin
          hi_ticks.push_back(hcnt);
        end
        buf_prev = data_strobe;
      end
      if (data_strobe) ccnt++;
      else if (ccnt > 0) begin
        hi_clks.push_back(ccnt);
        ccnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks expected completion", tests_run);
    $fatal(1, "bench did not complete");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_got(input int n, input string tag);
    int c = 0;
    while (got.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, got.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((busy !== 1'b0 || q0.size() > 0 || q1.size() > 0) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    int hb;
    int c;
    logic [9:0] exp_alt[4];
    logic [9:0] exp_abc[4];

    repeat (3) @(negedge clk);
    check_val("rst_grant", grant, 0);
    check_val("rst_ack", ack, 0);
    check_val("rst_data", data, 0);
    check_val("rst_strobe", data_strobe, 0);
    check_val("rst_busy", busy, 0);
`ifdef UART_ARB_WATCHDOG_EN
    check_val("rst_timeout", timeout_pulse, 0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 'A' from requester 0.
    base = got.size();
    hb   = hi_ticks.size();
    q0.push_back({1'b1, 8'h41});
    repeat (2) @(negedge clk);
    check_val("t1_grant", grant, 2'b01);
    check_val("t1_ack_early", ack, 0);
    check_val("t1_busy", busy, 1);
    @(negedge clk);
    check_val("t1_ack", ack, 2'b01);
    check_val("t1_data", data, 8'h41);
    check_val("t1_strobe", data_strobe, 1);
    @(negedge clk);
    check_val("t1_ack_pulse", ack, 0);
    wait_got(base + 1, "t1_writes");
    wait_idle("t1_idle");
    check_val("t1_byte", got[base], {2'b01, 8'h41});
    check_val("t1_hi_ticks", hi_ticks[hb], 2);
    check_val("t1_grant_end", grant, 0);
    check_val("t1_data_hold", data, 8'h41);

    // Round-robin alternation over four single-byte messages.
    do_reset();
    base = got.size();
    exp_alt[0] = {2'b01, 8'h31};
    exp_alt[1] = {2'b10, 8'h32};
    exp_alt[2] = {2'b01, 8'h33};
    exp_alt[3] = {2'b10, 8'h34};
    q0.push_back({1'b1, 8'h31}); q0.push_back({1'b1, 8'h33});
    q1.push_back({1'b1, 8'h32}); q1.push_back({1'b1, 8'h34});
    wait_got(base + 4, "t2_writes");
    wait_idle("t2_idle");
    for (int k = 0; k < 4; k++) check_val($sformatf("t2_msg%0d", k), got[base+k], exp_alt[k]);

    // Three-byte message keeps ownership while requester 1 waits.
    do_reset();
    base = got.size();
    hb   = hi_ticks.size();
    exp_abc[0] = {2'b01, 8'h61};
    exp_abc[1] = {2'b01, 8'h62};
    exp_abc[2] = {2'b01, 8'h63};
    exp_abc[3] = {2'b10, 8'h7a};
    q0.push_back({1'b0, 8'h61}); q0.push_back({1'b0, 8'h62}); q0.push_back({1'b1, 8'h63});
    q1.push_back({1'b1, 8'h7a});
    wait_got(base + 4, "t3_writes");
    wait_idle("t3_idle");
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t3_byte%0d", k), got[base+k], exp_abc[k]);
      check_val($sformatf("t3_hi%0d", k), hi_ticks[hb+k], 2);
    end

    // Reset during STROBE_HI, then requester 1 alone.
    do_reset();
    q0.push_back({1'b1, 8'h44});
    c = 0;
    while (data_strobe !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check_val("t4_strobe_hi", data_strobe, 1);
    reset = 1'b0;
    @(negedge clk);
    check_val("t4_strobe", data_strobe, 0);
    check_val("t4_grant", grant, 0);
    check_val("t4_ack", ack, 0);
    check_val("t4_busy", busy, 0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    base = got.size();
    q1.push_back({1'b1, 8'h5a});
    wait_got(base + 1, "t4_writes");
    wait_idle("t4_idle");
    check_val("t4_byte", got[base], {2'b10, 8'h5a});

    // baud_x1 tied high: ten-byte stream, strobe high exactly 2 clks each.
    do_reset();
    baud_fast = 1'b1;
    base = got.size();
    hb   = hi_clks.size();
    for (int k = 0; k < 10; k++) q0.push_back({(k == 9), 8'(8'h80 + k)});
    wait_got(base + 10, "t5_writes");
    wait_idle("t5_idle");
    check_val("t5_pulses", hi_clks.size() - hb, 10);
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("t5_byte%0d", k), got[base+k], {2'b01, 8'(8'h80 + k)});
      check_val($sformatf("t5_hiclk%0d", k), hi_clks[hb+k], 2);
    end
    baud_fast = 1'b0;

`ifdef UART_ARB_WATCHDOG_EN
    // Owner stalls after a non-last byte; watchdog releases to requester 1.
    do_reset();
    base = got.size();
    q0.push_back({1'b0, 8'h55});
    q1.push_back({1'b1, 8'h66});
    c = 0;
    while (timeout_pulse !== 1'b1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check_val("t6_timeout", timeout_pulse, 1);
    check_val("t6_grant", grant, 0);
    check_val("t6_no_byte", got.size(), base + 1);
    @(negedge clk);
    check_val("t6_pulse_len", timeout_pulse, 0);
    wait_got(base + 2, "t6_writes");
    wait_idle("t6_idle");
    check_val("t6_first", got[base], {2'b01, 8'h55});
    check_val("t6_next", got[base+1], {2'b10, 8'h66});
`else
    // Owner stalls after a non-last byte; grant is held until it finishes.
    do_reset();
    base = got.size();
    q0.push_back({1'b0, 8'h55});
    wait_got(base + 1, "t6_writes");
    repeat (40) @(negedge clk);
    check_val("t6_grant_held", grant, 2'b01);
    check_val("t6_busy_held", busy, 1);
    check_val("t6_no_extra", got.size(), base + 1);
    q0.push_back({1'b1, 8'h56});
    wait_got(base + 2, "t6_resume");
    wait_idle("t6_idle");
    check_val("t6_second", got[base+1], {2'b01, 8'h56});
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
